// File: rtl/sr_drv_pkg.sv
// Shared definitions for the master-slave SR flip-flop command driver.
package sr_drv_pkg;

    // Default phase lengths and counter width
    localparam int unsigned DEF_SETUP_CYCLES = 1;
    localparam int unsigned DEF_PULSE_CYCLES = 2;
    localparam int unsigned DEF_HOLD_CYCLES  = 1;
    localparam int unsigned DEF_CNT_W        = 4;

    // Accept-to-response latency for a legal command with the default timing
    localparam int unsigned LAT = DEF_SETUP_CYCLES + DEF_PULSE_CYCLES + DEF_HOLD_CYCLES + 2;

    // Command encodings
    localparam logic [1:0] CMD_HOLD  = 2'b00;
    localparam logic [1:0] CMD_RESET = 2'b01;
    localparam logic [1:0] CMD_SET   = 2'b10;
    localparam logic [1:0] CMD_ILL   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_CHECK,
        ST_RESP
    } sr_state_t;

    // Response payload
    typedef struct packed {
        logic ok;
        logic q;
    } sr_rsp_t;

    // S/R levels for a command, packed as {s, r}
    function automatic logic [1:0] cmd_to_sr(input logic [1:0] cmd);
        case (cmd)
            CMD_SET:   return 2'b10;
            CMD_RESET: return 2'b01;
            default:   return 2'b00;
        endcase
    endfunction

    // Q value the flip-flop must show once the command has been applied
    function automatic logic cmd_expected(input logic [1:0] cmd, input logic q_now);
        case (cmd)
            CMD_SET:   return 1'b1;
            CMD_RESET: return 1'b0;
            default:   return q_now;
        endcase
    endfunction

endpackage

// File: rtl/sr_phase_timer.sv
// Phase length counter: loads N-1 on phase entry, counts down, done at zero.
module sr_phase_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt_q;

    // Load on phase entry, otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done_c = (cnt_q == '0);

endmodule

// File: rtl/sr_ff_driver.sv
// Command-side driver for one master-slave SR flip-flop: sequences S/R setup,
// clock pulse and hold, then samples Q and returns a checked response.
// Optional build macro SR_MIDQ_CHECK_EN: also require the master latch
// (ff_mid_q) to show the expected value on the last pulse cycle.
module sr_ff_driver
    import sr_drv_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_cmd,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_ok,
    output logic       rsp_q,
    output logic       ff_s,
    output logic       ff_r,
    output logic       ff_clk,
    input  logic       ff_q,
    input  logic       ff_qbar,
    input  logic       ff_mid_q
);

    sr_state_t        state_q, state_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    sr_rsp_t          rsp_reg_q, rsp_d;
    logic             ff_s_q, ff_s_d;
    logic             ff_r_q, ff_r_d;
    logic             ff_clk_q, ff_clk_d;
    logic             exp_q, exp_d;
    logic             timer_load_c;
    logic [CNT_W-1:0] timer_val_c;
    logic             timer_done_c;

`ifdef SR_MIDQ_CHECK_EN
    logic             midq_ok_q, midq_ok_d;
`else
    logic             unused_mid_q;
    assign unused_mid_q = ff_mid_q;
`endif

    sr_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load_c),
        .load_val (timer_val_c),
        .done_c   (timer_done_c)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_reg_q   <= '0;
            ff_s_q      <= 1'b0;
            ff_r_q      <= 1'b0;
            ff_clk_q    <= 1'b0;
            exp_q       <= 1'b0;
`ifdef SR_MIDQ_CHECK_EN
            midq_ok_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_reg_q   <= rsp_d;
            ff_s_q      <= ff_s_d;
            ff_r_q      <= ff_r_d;
            ff_clk_q    <= ff_clk_d;
            exp_q       <= exp_d;
`ifdef SR_MIDQ_CHECK_EN
            midq_ok_q   <= midq_ok_d;
`endif
        end
    end

    // Next state and next output values; outputs change together with the state
    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_d        = rsp_reg_q;
        ff_s_d       = ff_s_q;
        ff_r_d       = ff_r_q;
        ff_clk_d     = ff_clk_q;
        exp_d        = exp_q;
        timer_load_c = 1'b0;
        timer_val_c  = '0;
`ifdef SR_MIDQ_CHECK_EN
        midq_ok_d    = midq_ok_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    if (req_cmd == CMD_ILL) begin
                        // Illegal command: answer at once, no flip-flop activity
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_d.ok    = 1'b0;
                        rsp_d.q     = ff_q;
                    end else begin
                        state_d          = ST_SETUP;
                        {ff_s_d, ff_r_d} = cmd_to_sr(req_cmd);
                        ff_clk_d         = 1'b0;
                        exp_d            = cmd_expected(req_cmd, ff_q);
                        timer_load_c     = 1'b1;
                        timer_val_c      = CNT_W'(SETUP_CYCLES - 1);
                    end
                end
            end

            ST_SETUP: begin
                if (timer_done_c) begin
                    state_d      = ST_PULSE;
                    ff_clk_d     = 1'b1;
                    timer_load_c = 1'b1;
                    timer_val_c  = CNT_W'(PULSE_CYCLES - 1);
                end
            end

            ST_PULSE: begin
                if (timer_done_c) begin
                    state_d      = ST_HOLD;
                    ff_clk_d     = 1'b0;
                    timer_load_c = 1'b1;
                    timer_val_c  = CNT_W'(HOLD_CYCLES - 1);
`ifdef SR_MIDQ_CHECK_EN
                    midq_ok_d    = (ff_mid_q == exp_q);
`endif
                end
            end

            ST_HOLD: begin
                if (timer_done_c) begin
                    state_d = ST_CHECK;
                    ff_s_d  = 1'b0;
                    ff_r_d  = 1'b0;
                end
            end

            ST_CHECK: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_d.q     = ff_q;
`ifdef SR_MIDQ_CHECK_EN
                rsp_d.ok    = (ff_q == exp_q) && (ff_qbar == ~ff_q) && midq_ok_q;
`else
                rsp_d.ok    = (ff_q == exp_q) && (ff_qbar == ~ff_q);
`endif
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                ff_s_d      = 1'b0;
                ff_r_d      = 1'b0;
                ff_clk_d    = 1'b0;
            end
        endcase
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_ok    = rsp_reg_q.ok;
    assign rsp_q     = rsp_reg_q.q;
    assign ff_s      = ff_s_q;
    assign ff_r      = ff_r_q;
    assign ff_clk    = ff_clk_q;

endmodule
